// File: rtl/sd_route_mux_if.sv
// Bundle of SD mux signals: core SPI master side, physical card, virtual card emulators, mount events and status.
// The mux uses the slave modport; the surrounding system (or a bench) drives through the master modport.
interface sd_route_mux_if #(
  parameter int N_VSD = 2
);
  localparam int SW = $clog2(N_VSD + 1);

  logic [N_VSD-1:0] img_mounted;
  logic [N_VSD-1:0] img_nz;
  logic             sd_cs_n;
  logic             sd_sck;
  logic             sd_mosi;
  logic             sd_miso;
  logic             phys_cs_n;
  logic             phys_sck;
  logic             phys_mosi;
  logic             phys_miso;
  logic [N_VSD-1:0] vsd_ss_n;
  logic [N_VSD-1:0] vsd_miso;
  logic [SW-1:0]    sel;
  logic             act_phys;
  logic             act_vsd;
  logic             reset_req;

  modport slave (
    input  img_mounted, img_nz, sd_cs_n, sd_sck, sd_mosi, phys_miso, vsd_miso,
    output sd_miso, phys_cs_n, phys_sck, phys_mosi, vsd_ss_n, sel, act_phys, act_vsd, reset_req
  );

  modport master (
    output img_mounted, img_nz, sd_cs_n, sd_sck, sd_mosi, phys_miso, vsd_miso,
    input  sd_miso, phys_cs_n, phys_sck, phys_mosi, vsd_ss_n, sel, act_phys, act_vsd, reset_req
  );
endinterface

// File: rtl/sd_route_mux.sv
// SD SPI router: core bus goes to the physical card or a virtual slot; sel changes one edge after a mount request, only while sd_cs_n=1.
// Routing is combinational, activity flags registered; macro SD_MOUNT_RESET_EN adds a RST_LEN-cycle reset_req per mount pulse.
module sd_route_mux #(
  parameter int N_VSD       = 2,
  parameter int ACT_TIMEOUT = 1000000,
  parameter int RST_LEN     = 10000000
) (
  input  logic          clk_sys,
  input  logic          reset,
  sd_route_mux_if.slave bus
);
  localparam int SW   = $clog2(N_VSD + 1);
  localparam int CMAX = (ACT_TIMEOUT > RST_LEN) ? ACT_TIMEOUT : RST_LEN;
  localparam int CW   = $clog2(CMAX + 1);

  logic [SW-1:0]    sel_q, sel_d;
  logic [SW-1:0]    pend_tgt_q, pend_tgt_d;
  logic             pend_vld_q, pend_vld_d;
  logic [SW-1:0]    req_tgt;
  logic             req_vld;
  logic [CW-1:0]    act_cnt_q, act_cnt_d;
  logic             act_q, mosi_q, miso_q;
  logic             sel_phys, phys_cs_n_w, sd_miso_w, act_edge;
  logic [N_VSD-1:0] vsd_ss_n_w;

  assign sel_phys    = (sel_q == '0);
  assign phys_cs_n_w = ~sel_phys | bus.sd_cs_n;

  always_comb begin
    sd_miso_w  = bus.phys_miso;
    vsd_ss_n_w = '1;
    for (int k = 0; k < N_VSD; k++) begin
      vsd_ss_n_w[k] = (sel_q != SW'(k + 1)) | bus.sd_cs_n;
      if (sel_q == SW'(k + 1)) sd_miso_w = bus.vsd_miso[k];
    end
  end

  // Scan from the top slot down so the lowest requesting slot is the one left standing.
  always_comb begin
    req_vld = 1'b0;
    req_tgt = '0;
    for (int k = N_VSD - 1; k >= 0; k--) begin
      if (bus.img_mounted[k]) begin
        if (bus.img_nz[k]) begin
          req_vld = 1'b1;
          req_tgt = SW'(k + 1);
        end else if ((sel_q == SW'(k + 1)) || (pend_vld_q && (pend_tgt_q == SW'(k + 1)))) begin
          req_vld = 1'b1;
          req_tgt = '0;
        end
      end
    end
  end

  always_comb begin
    sel_d      = sel_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    if (req_vld) begin
      if (bus.sd_cs_n) begin
        sel_d      = req_tgt;
        pend_vld_d = 1'b0;
      end else begin
        pend_vld_d = 1'b1;
        pend_tgt_d = req_tgt;
      end
    end else if (pend_vld_q && bus.sd_cs_n) begin
      sel_d      = pend_tgt_q;
      pend_vld_d = 1'b0;
    end
  end

  assign act_edge = (bus.sd_mosi ^ mosi_q) | (sd_miso_w ^ miso_q);

  always_comb begin
    act_cnt_d = act_cnt_q;
    if (act_edge)                           act_cnt_d = '0;
    else if (act_cnt_q < CW'(ACT_TIMEOUT))  act_cnt_d = act_cnt_q + CW'(1);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sel_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
      act_cnt_q  <= CW'(ACT_TIMEOUT);
      act_q      <= 1'b0;
      mosi_q     <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      act_cnt_q  <= act_cnt_d;
      act_q      <= (act_cnt_q < CW'(ACT_TIMEOUT));
      mosi_q     <= bus.sd_mosi;
      miso_q     <= sd_miso_w;
    end
  end

`ifdef SD_MOUNT_RESET_EN
  logic [CW-1:0] rst_cnt_q, rst_cnt_d;

  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if (|bus.img_mounted)        rst_cnt_d = CW'(RST_LEN);
    else if (rst_cnt_q != '0)    rst_cnt_d = rst_cnt_q - CW'(1);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) rst_cnt_q <= '0;
    else       rst_cnt_q <= rst_cnt_d;
  end

  assign bus.reset_req = (rst_cnt_q != '0);
`else
  assign bus.reset_req = 1'b0;
`endif

  assign bus.phys_cs_n = phys_cs_n_w;
  assign bus.phys_sck  = bus.sd_sck & ~phys_cs_n_w;
  assign bus.phys_mosi = bus.sd_mosi & ~phys_cs_n_w;
  assign bus.vsd_ss_n  = vsd_ss_n_w;
  assign bus.sd_miso   = sd_miso_w;
  assign bus.sel       = sel_q;
  assign bus.act_phys  = act_q & sel_phys;
  assign bus.act_vsd   = act_q & ~sel_phys;
endmodule

// File: tb/tb_sd_route_mux.sv
// Bench for sd_route_mux (N_VSD=2, ACT_TIMEOUT=8, RST_LEN=16): directed scenarios then random traffic vs a cycle-level reference model.
module tb_sd_route_mux;
  localparam int NV    = 2;
  localparam int ACT_T = 8;
  localparam int RST_L = 16;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  // reference model state
  int m_sel, m_pv, m_pt;
  int n_edge;
  int lc, lp;
  bit lc_vld, lp_vld, m_act;
  bit pm, pmi;

  sd_route_mux_if #(.N_VSD(NV)) bus ();

  sd_route_mux #(.N_VSD(NV), .ACT_TIMEOUT(ACT_T), .RST_LEN(RST_L)) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_miso();
    if (m_sel == 0) return bus.phys_miso;
    return bus.vsd_miso[m_sel-1];
  endfunction

  function automatic bit exp_rreq();
`ifdef SD_MOUNT_RESET_EN
    return lp_vld && ((n_edge - lp) < RST_L);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_sel = 0; m_pv = 0; m_pt = 0; n_edge = 0;
    lc = 0; lp = 0; lc_vld = 0; lp_vld = 0; m_act = 0; pm = 0; pmi = 0;
  endtask

  task automatic chk_all(input string tag);
    bit pcs;
    logic [NV-1:0] ss;
    pcs = (m_sel != 0) || bus.sd_cs_n;
    for (int k = 0; k < NV; k++) ss[k] = (m_sel != k + 1) || bus.sd_cs_n;
    chk({tag, ".sel"},       bus.sel,       m_sel);
    chk({tag, ".phys_cs_n"}, bus.phys_cs_n, pcs);
    chk({tag, ".phys_sck"},  bus.phys_sck,  bus.sd_sck && !pcs);
    chk({tag, ".phys_mosi"}, bus.phys_mosi, bus.sd_mosi && !pcs);
    chk({tag, ".vsd_ss_n"},  bus.vsd_ss_n,  ss);
    chk({tag, ".sd_miso"},   bus.sd_miso,   exp_miso());
    chk({tag, ".act_phys"},  bus.act_phys,  m_act && (m_sel == 0));
    chk({tag, ".act_vsd"},   bus.act_vsd,   m_act && (m_sel != 0));
    chk({tag, ".reset_req"}, bus.reset_req, exp_rreq());
  endtask

  // One clock: evaluate rules on current inputs, take the edge, commit model, return at the next negedge.
  task automatic cyc();
    bit rv, tog, act_e, pulse, mi;
    int rt;
    rv = 0; rt = 0;
    for (int k = 0; k < NV; k++) begin
      if (!rv && bus.img_mounted[k]) begin
        if (bus.img_nz[k]) begin
          rv = 1; rt = k + 1;
        end else if (m_sel == k + 1 || (m_pv != 0 && m_pt == k + 1)) begin
          rv = 1; rt = 0;
        end
      end
    end
    mi    = exp_miso();
    tog   = (bus.sd_mosi != pm) || (mi != pmi);
    act_e = lc_vld && ((n_edge - lc) < ACT_T);
    pulse = |bus.img_mounted;
    @(posedge clk_sys);
    n_edge++;
    if (rv) begin
      if (bus.sd_cs_n) begin m_sel = rt; m_pv = 0; end
      else begin m_pv = 1; m_pt = rt; end
    end else if (m_pv != 0 && bus.sd_cs_n) begin
      m_sel = m_pt; m_pv = 0;
    end
    pm = bus.sd_mosi; pmi = mi;
    if (tog) begin lc = n_edge; lc_vld = 1; end
    m_act = act_e;
    if (pulse) begin lp = n_edge; lp_vld = 1; end
    @(negedge clk_sys);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    #1;
    chk("rst.sel",       bus.sel,       0);
    chk("rst.act_phys",  bus.act_phys,  0);
    chk("rst.act_vsd",   bus.act_vsd,   0);
    chk("rst.reset_req", bus.reset_req, 0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic idle_inputs();
    bus.img_mounted = '0; bus.img_nz = '0;
    bus.sd_sck = 0; bus.sd_mosi = 0; bus.phys_miso = 0; bus.vsd_miso = '0;
  endtask

  initial begin
    int hi;
    model_reset();
    idle_inputs();
    bus.sd_cs_n = 1;
    do_reset();

    // quiet bus after reset: no activity flagged
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("quiet.act_phys", bus.act_phys, 0);
      chk_all("quiet");
    end

    // mount slot 0 while idle -> immediate switch
    bus.img_mounted = 2'b01; bus.img_nz = 2'b01;
    cyc();
    bus.img_mounted = '0;
    chk("m0.sel", bus.sel, 1);
    chk("m0.phys_cs_n", bus.phys_cs_n, 1);
    bus.sd_cs_n = 0; bus.vsd_miso = 2'b01; #1;
    chk("m0.vsd_ss_n0", bus.vsd_ss_n[0], 0);
    chk("m0.miso_a", bus.sd_miso, 1);
    bus.vsd_miso = 2'b10; #1;
    chk("m0.miso_b", bus.sd_miso, 0);
    chk_all("m0");

    // mount slot 1 mid-transaction -> deferred until cs_n rises
    bus.img_mounted = 2'b10; bus.img_nz = 2'b10;
    cyc();
    bus.img_mounted = '0;
    for (int i = 0; i < 3; i++) begin
      chk("m1.hold", bus.sel, 1);
      chk_all("m1h");
      cyc();
    end
    chk("m1.hold_last", bus.sel, 1);
    bus.sd_cs_n = 1;
    cyc();
    chk("m1.applied", bus.sel, 2);
    chk_all("m1");

    // simultaneous mounts: lowest slot wins; then unmount slot 0
    bus.img_mounted = 2'b11; bus.img_nz = 2'b11;
    cyc();
    chk("sim.sel", bus.sel, 1);
    bus.img_mounted = 2'b01; bus.img_nz = 2'b00;
    cyc();
    bus.img_mounted = '0;
    chk("unm.sel", bus.sel, 0);
    chk_all("unm");

    // single mosi toggle at sel=0: act_phys high exactly 8 cycles after the clear edge
    idle_inputs();
    do_reset();
    cyc(); cyc();
    bus.sd_mosi = 1;
    for (int j = 1; j <= 12; j++) begin
      cyc();
      chk($sformatf("act.j%0d", j), bus.act_phys, (j >= 2 && j <= ACT_T + 1) ? 1 : 0);
      chk_all("act");
    end

    // mount-reset pulse length, single and restarted
    idle_inputs();
    do_reset();
    bus.img_mounted = 2'b01;
    hi = 0;
    for (int j = 1; j <= 30; j++) begin
      cyc();
      bus.img_mounted = '0;
      if (bus.reset_req) hi++;
      chk_all("rr1");
    end
`ifdef SD_MOUNT_RESET_EN
    chk("rr1.len", hi, RST_L);
`else
    chk("rr1.len", hi, 0);
`endif
    do_reset();
    hi = 0;
    bus.img_mounted = 2'b01;
    for (int j = 1; j <= 40; j++) begin
      cyc();
      bus.img_mounted = (j == 10) ? 2'b01 : 2'b00;
      if (bus.reset_req) hi = j;
      chk_all("rr2");
    end
`ifdef SD_MOUNT_RESET_EN
    chk("rr2.last_high", hi, 26);
`else
    chk("rr2.last_high", hi, 0);
`endif

    // reset with a pending switch discards it
    idle_inputs();
    bus.sd_cs_n = 0;
    bus.img_mounted = 2'b01; bus.img_nz = 2'b01;
    cyc();
    bus.img_mounted = '0;
    chk("pr.pending", bus.sel, 0);
    do_reset();
    cyc();
    bus.sd_cs_n = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("pr.no_switch", bus.sel, 0);
    end

    // random traffic vs model
    for (int i = 0; i < 400; i++) begin
      bus.sd_cs_n     = ($urandom_range(0, 2) != 0);
      bus.sd_sck      = $urandom_range(0, 1);
      bus.sd_mosi     = ($urandom_range(0, 5) == 0) ? ~bus.sd_mosi : bus.sd_mosi;
      bus.phys_miso   = $urandom_range(0, 1);
      bus.vsd_miso    = NV'($urandom_range(0, 3));
      for (int k = 0; k < NV; k++) begin
        bus.img_mounted[k] = ($urandom_range(0, 7) == 0);
        bus.img_nz[k]      = $urandom_range(0, 1);
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.sd_mosi = 0; bus.phys_miso = 0; bus.vsd_miso = '0;
      end
      #1;
      chk_all("rnd.pre");
      cyc();
      chk_all("rnd.post");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sd_route_mux.md
SD_ROUTE_MUX -- requirements
Module: sd_route_mux

Interface
REQ-001 SHALL have parameter N_VSD, default 2, number of virtual SD slots, legal range 1..4.
REQ-002 SHALL have parameter ACT_TIMEOUT, default 1000000, activity hold time in clk_sys cycles.
REQ-003 SHALL have parameter RST_LEN, default 10000000, mount-reset pulse length in clk_sys cycles.
REQ-004 SHALL have port clk_sys  in  1  single system clock; all state on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports img_mounted  in  N_VSD  one-cycle mount pulse per slot; img_nz  in  N_VSD  image size nonzero, valid with the pulse.
REQ-007 SHALL have ports sd_cs_n, sd_sck, sd_mosi  in  1 each  core SPI master; sd_miso  out  1  to core.
REQ-008 SHALL have ports phys_cs_n, phys_sck, phys_mosi  out  1 each; phys_miso  in  1  physical card.
REQ-009 SHALL have ports vsd_ss_n  out  N_VSD; vsd_miso  in  N_VSD  virtual card emulators.
REQ-010 SHALL have ports sel  out  SW=$clog2(N_VSD+1)  active slot (0 = physical, k = virtual slot k-1); act_phys, act_vsd  out  1 each; reset_req  out  1.

Function
REQ-011 SHALL route combinationally: phys_cs_n = (sel!=0) | sd_cs_n; phys_sck = sd_sck & ~phys_cs_n; phys_mosi = sd_mosi & ~phys_cs_n.
REQ-012 SHALL drive vsd_ss_n[k] = (sel!=k+1) | sd_cs_n; sd_miso = phys_miso when sel==0, else vsd_miso[sel-1].
REQ-013 SHALL, on img_mounted[k] with img_nz[k]=1, request target k+1; with img_nz[k]=0 and sel==k+1 (or pending target k+1), request target 0; otherwise no request.
REQ-014 SHALL resolve simultaneous mount pulses by lowest slot index.
REQ-015 SHALL apply a request to sel on the next edge if sd_cs_n=1; else hold it in a pending register and apply it on the first cycle sd_cs_n=1 (never switch mid-transaction).
REQ-016 SHALL let a newer request overwrite an unapplied pending one.
REQ-017 SHALL register sd_mosi and sd_miso each cycle; an edge on either SHALL clear activity counter to 0.
REQ-018 SHALL increment the activity counter while below ACT_TIMEOUT, saturating at ACT_TIMEOUT.
REQ-019 SHALL register act = (counter < ACT_TIMEOUT); act_phys = act & (sel==0); act_vsd = act & (sel!=0).
REQ-020 SHALL size counters to hold max(ACT_TIMEOUT, RST_LEN) without wrap.

Reset
REQ-021 SHALL, while reset=1, force sel=0, pending empty, activity counter=ACT_TIMEOUT, act_phys=act_vsd=0, reset_req=0, edge registers=0.
REQ-022 SHALL discard any pending switch when reset asserts mid-transaction.

Configuration
REQ-023 SHALL honour macro SD_MOUNT_RESET_EN: when defined, any img_mounted pulse sets reset_req=1 next cycle and loads a down-counter with RST_LEN; reset_req falls after RST_LEN cycles; a new pulse restarts the count.
REQ-024 SHALL, when SD_MOUNT_RESET_EN is undefined, tie reset_req to 0 and omit the down-counter.

Verification
REQ-025 Bench SHALL check: sd_cs_n=1, img_mounted=2'b01, img_nz=2'b01 -> sel=1 next cycle, vsd_ss_n[0] follows sd_cs_n, phys_cs_n=1, sd_miso=vsd_miso[0].
REQ-026 Bench SHALL check: sd_cs_n=0, mount slot 1 (nz) -> sel unchanged until sd_cs_n rises, then sel=2 on following edge.
REQ-027 Bench SHALL check: img_mounted=2'b11, img_nz=2'b11 same cycle -> sel=1; then unmount slot 0 (img_nz=0) -> sel=0.
REQ-028 Bench SHALL check with ACT_TIMEOUT=8: one sd_mosi toggle at sel=0 -> act_phys=1 for 8 cycles after the clear, then 0; no toggles after reset -> act_phys stays 0.
REQ-029 Bench SHALL check with RST_LEN=16, macro defined: mount pulse -> reset_req high 16 cycles; second pulse at cycle 10 -> high until cycle 26; macro undefined -> reset_req always 0.
REQ-030 Bench SHALL check: reset asserted with pending switch and sd_cs_n=0 -> after release sel=0, no switch when sd_cs_n rises.
